uart_byte_transmitter: RTL and testbench



---
 rtl/uart_byte_transmitter.sv | 183 ++++++++++++++++++
 tb/tb_uart_byte_transmitter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_byte_transmitter.sv
// Purpose : serialises bytes into UART frames (start, 8 data LSB first, [parity], stop) on tx_out.
// Latency : byte accepted at edge E0 while idle with CTS low drives the start bit from E1;
//           a frame lasts (9+StopBits)*ClocksPerBaud cycles, (10+StopBits)*ClocksPerBaud with parity.
// Backpressure: one-entry holding register; tx_byte_ready is low while it is occupied, and a held
//           byte waits for clear_to_send_in_n low at the next frame-start decision.
//
// Ports:
//   clk, rst            single clock, asynchronous active-high reset
//   tx_byte/_valid      byte to send; transfer on tx_byte_valid && tx_byte_ready at a rising edge
//   tx_byte_ready       holding register empty (driven directly from a flop)
//   clear_to_send_in_n  active-low permission from the far end, sampled only when a frame starts
//   tx_out              serial line, idles high, driven from a flop
//   tx_busy             frame in progress or byte held
// Build option: define UART_TX_PARITY_EN to add an even-parity bit between data and stop.

module uart_byte_transmitter #(
  parameter int ClocksPerBaud = 8,
  parameter int StopBits      = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_byte,
  input  logic       tx_byte_valid,
  output logic       tx_byte_ready,
  input  logic       clear_to_send_in_n,
  output logic       tx_out,
  output logic       tx_busy
);

  localparam int CntW = (ClocksPerBaud > 1) ? $clog2(ClocksPerBaud) : 1;
  localparam logic [CntW-1:0] CntLast  = CntW'(ClocksPerBaud - 1);
  localparam logic [2:0]      StopLast = 3'(StopBits - 1);

  if (StopBits != 1 && StopBits != 2) begin : g_bad_stop_bits
    $error("uart_byte_transmitter: StopBits must be 1 or 2");
  end

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t          state_q, state_d;
  logic [CntW-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      hold_q, hold_d;
  logic            hold_valid_q, hold_valid_d;
  logic            tx_q, tx_d;
  logic            bit_done;
  logic            start_ok;
  logic            take;
`ifdef UART_TX_PARITY_EN
  logic            parity_q, parity_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      baud_cnt_q   <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      tx_q         <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      baud_cnt_q   <= baud_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      tx_q         <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q     <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    take         = 1'b0;
    tx_d         = 1'b1;
`ifdef UART_TX_PARITY_EN
    parity_d     = parity_q;
`endif

    bit_done = (baud_cnt_q == CntLast);
    // CTS only matters here, at a frame-start decision; a running frame always completes.
    start_ok = hold_valid_q && !clear_to_send_in_n;

    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_d = S_START;
          take    = 1'b1;
        end
      end
      S_START: begin
        if (bit_done) begin
          state_d   = S_DATA;
          bit_idx_d = '0;
        end
      end
      S_DATA: begin
        if (bit_done) begin
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = S_PARITY;
`else
            state_d   = S_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = shift_q >> 1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_done) begin
          state_d   = S_STOP;
          bit_idx_d = '0;
        end
      end
`endif
      S_STOP: begin
        // bit_idx counts stop-bit periods so the baud counter stays one bit period wide.
        if (bit_done) begin
          if (bit_idx_q == StopLast) begin
            if (start_ok) begin
              state_d = S_START;
              take    = 1'b1;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    baud_cnt_d = (state_q == S_IDLE || bit_done) ? '0 : baud_cnt_q + 1'b1;

    if (take) begin
      shift_d      = hold_q;
      hold_valid_d = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d     = ^hold_q;
`endif
    end else if (tx_byte_valid && !hold_valid_q) begin
      // tx_byte is only captured under valid, so X on an idle bus never reaches state.
      hold_d       = tx_byte;
      hold_valid_d = 1'b1;
    end

    // Line value for the coming cycle, registered so tx_out cannot glitch.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = parity_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  assign tx_out        = tx_q;
  assign tx_byte_ready = !hold_valid_q;
  assign tx_busy       = (state_q != S_IDLE) || hold_valid_q;

endmodule

// File: tb/tb_uart_byte_transmitter.sv
// Directed bench for uart_byte_transmitter: a line monitor decodes frames from tx_out and
// compares them with bytes queued at send time; timing checks use a posedge cycle counter.
module tb_uart_byte_transmitter;

  localparam int CPB = 8;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FB1 = 10 + PAR;  // bit periods per frame, one stop bit
  localparam int FB2 = 11 + PAR;  // bit periods per frame, two stop bits

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_byte, tx_byte2;
  logic       valid, valid2;
  logic       ready, ready2;
  logic       cts_n;
  logic       tx1, tx2;
  logic       busy1, busy2;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] exp_q[$];
  int         start_q[$];

  uart_byte_transmitter #(.ClocksPerBaud(CPB), .StopBits(1)) dut (
    .clk(clk), .rst(rst), .tx_byte(tx_byte), .tx_byte_valid(valid), .tx_byte_ready(ready),
    .clear_to_send_in_n(cts_n), .tx_out(tx1), .tx_busy(busy1)
  );

  uart_byte_transmitter #(.ClocksPerBaud(CPB), .StopBits(2)) dut2 (
    .clk(clk), .rst(rst), .tx_byte(tx_byte2), .tx_byte_valid(valid2), .tx_byte_ready(ready2),
    .clear_to_send_in_n(1'b0), .tx_out(tx2), .tx_busy(busy2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Line monitor for dut: samples each bit mid-period and scores data against exp_q.
  logic       m_on = 1'b0;
  int         m_cnt = 0;
  int         m_b;
  logic [7:0] m_rx;
  logic [7:0] m_exp;

  always @(negedge clk) begin
    if (rst) begin
      m_on = 1'b0;
    end else if (!m_on) begin
      if (tx1 === 1'b0) begin
        m_on  = 1'b1;
        m_cnt = 0;
        start_q.push_back(cyc);
      end
    end else begin
      m_cnt++;
    end
    if (m_on && !rst && (m_cnt % CPB) == CPB / 2) begin
      m_b = m_cnt / CPB;
      if (m_b == 0) begin
        check("mon_start_bit", 32'(tx1), 32'd0);
      end else if (m_b <= 8) begin
        m_rx[m_b-1] = tx1;
        if (m_b == 8) begin
          m_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
          check("mon_data", 32'(m_rx), 32'(m_exp));
        end
      end else if (m_b <= 8 + PAR) begin
        check("mon_parity", 32'(tx1), 32'(^m_exp));
      end else begin
        check("mon_stop_bit", 32'(tx1), 32'd1);
      end
      if (m_b == FB1 - 1) m_on = 1'b0;
    end
  end

  task automatic send(input logic [7:0] b, output int acc);
    int n = 0;
    @(negedge clk);
    while (!ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", 32'(ready), 32'd1);
    tx_byte = b;
    valid   = 1'b1;
    exp_q.push_back(b);
    @(posedge clk);
    #1;
    acc     = cyc;
    valid   = 1'b0;
    tx_byte = 8'hxx;
  endtask

  task automatic wait_idle(output int c);
    int n = 0;
    @(negedge clk);
    while (busy1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    c = cyc;
  endtask

  task automatic pop_start(output int s);
    s = (start_q.size() > 0) ? start_q.pop_front() : -1;
  endtask

  initial begin
    int c0, c1, c, s, s2, cf, viol, mism, k;
    logic expb;

    rst = 1'b1; tx_byte = 8'hxx; valid = 1'b0; cts_n = 1'b0;
    tx_byte2 = 8'hxx; valid2 = 1'b0;
    #1;
    check("rst_tx_out", 32'(tx1), 32'd1);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_busy", 32'(busy1), 32'd0);
    check("rst_tx_out2", 32'(tx2), 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Single byte 0x55
    send(8'h55, c0);
    @(negedge clk);
    check("single_ready_low", 32'(ready), 32'd0);
    check("single_line_idle_e0", 32'(tx1), 32'd1);
    @(negedge clk);
    check("single_ready_back", 32'(ready), 32'd1);
    check("single_start_e1", 32'(tx1), 32'd0);
    wait_idle(c);
    check("single_busy_fall", 32'(c), 32'(c0 + FB1 * CPB + 1));
    pop_start(s);
    check("single_start_cycle", 32'(s), 32'(c0 + 1));

    // Back-to-back 0xA5, 0x3C
    send(8'hA5, c0);
    send(8'h3C, c1);
    check("b2b_second_accept", 32'(c1), 32'(c0 + 2));
    wait_idle(c);
    check("b2b_busy_fall", 32'(c), 32'(c0 + 2 * FB1 * CPB + 1));
    pop_start(s);
    pop_start(s2);
    check("b2b_first_start", 32'(s), 32'(c0 + 1));
    check("b2b_no_gap", 32'(s2 - s), 32'(FB1 * CPB));

    // CTS gating: 0x81 held, 0x42 must not be accepted
    @(negedge clk);
    cts_n = 1'b1;
    send(8'h81, c0);
    viol = 0;
    tx_byte = 8'h42;
    valid   = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (ready !== 1'b0 || tx1 !== 1'b1 || busy1 !== 1'b1) viol++;
    end
    valid   = 1'b0;
    tx_byte = 8'hxx;
    check("cts_hold_violations", 32'(viol), 32'd0);
    @(negedge clk);
    cts_n = 1'b0;
    cf = cyc;
    repeat (5) @(negedge clk);
    check("cts_frame_busy", 32'(busy1), 32'd1);
    check("cts_frame_start_bit", 32'(tx1), 32'd0);
    wait_idle(c);
    check("cts_busy_fall", 32'(c), 32'(cf + 1 + FB1 * CPB));
    pop_start(s);
    check("cts_start_cycle", 32'(s), 32'(cf + 1));

    // Reset during data bit 3 of 0xF0, then a clean 0x0F
    send(8'hF0, c0);
    while (cyc < c0 + 36) @(negedge clk);
    check("rst_mid_bit3_low", 32'(tx1), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_tx_out", 32'(tx1), 32'd1);
    check("rst_mid_ready", 32'(ready), 32'd1);
    check("rst_mid_busy", 32'(busy1), 32'd0);
    exp_q.delete();
    start_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    send(8'h0F, c0);
    wait_idle(c);
    check("post_rst_busy_fall", 32'(c), 32'(c0 + FB1 * CPB + 1));
    pop_start(s);
    check("post_rst_start", 32'(s), 32'(c0 + 1));

    // 0x07 then 0x03 (parity 1 then 0 when the parity bit is built in)
    send(8'h07, c0);
    send(8'h03, c1);
    wait_idle(c);
    check("par_pair_busy_fall", 32'(c), 32'(c0 + 2 * FB1 * CPB + 1));
    pop_start(s);
    pop_start(s2);
    check("par_pair_spacing", 32'(s2 - s), 32'(FB1 * CPB));

    // Two stop bits: 0x00 twice back-to-back on dut2, checked cycle by cycle
    @(negedge clk);
    check("two_stop_ready", 32'(ready2), 32'd1);
    tx_byte2 = 8'h00;
    valid2   = 1'b1;
    @(posedge clk);
    #1;
    c0       = cyc;
    valid2   = 1'b0;
    tx_byte2 = 8'hxx;
    mism = 0;
    k    = 0;
    while (k < 2 * FB2 * CPB) begin
      @(negedge clk);
      k = cyc - c0;
      if (k == 0) begin
        check("two_stop_idle_e0", 32'(tx2), 32'd1);
      end else begin
        expb = (((k - 1) % (FB2 * CPB)) / CPB) >= FB2 - 2;
        if (tx2 !== expb) mism++;
      end
      if (k == 1) begin
        tx_byte2 = 8'h00;
        valid2   = 1'b1;
      end
      if (k == 2) begin
        valid2   = 1'b0;
        tx_byte2 = 8'hxx;
        check("two_stop_second_held", 32'(ready2), 32'd0);
      end
    end
    check("two_stop_waveform_mismatches", 32'(mism), 32'd0);
    check("two_stop_busy_last_cycle", 32'(busy2), 32'd1);
    @(negedge clk);
    check("two_stop_busy_fall", 32'(busy2), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
